// File: rtl/sccb_pkg.sv
// Shared constants for the SCCB write master: FSM state encodings, frame geometry
// and the default OV7670 write ID.
package sccb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] BIT   = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int SCCB_BITS_PER_BYTE = 9;
    localparam int SCCB_BYTES         = 3;

    localparam logic [7:0] OV7670_WRITE_ID = 8'h42;

    localparam int BIT_W  = $clog2(SCCB_BITS_PER_BYTE);
    localparam int BYTE_W = $clog2(SCCB_BYTES);

endpackage

// File: rtl/sccb_if.sv
// Request/handshake and open-drain pad controls between the configuration
// sequencer, the SCCB master and the board tri-state pads.
interface sccb_if;

    logic       start;
    logic [7:0] address;
    logic [7:0] data;
    logic       ready;
    logic       SIOC_oe;
    logic       SIOD_oe;

    modport master (
        input  start, address, data,
        output ready, SIOC_oe, SIOD_oe
    );

    modport slave (
        output start, address, data,
        input  ready, SIOC_oe, SIOD_oe
    );

endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-period strobe: one-cycle tick every QUARTER clocks, restarted by clear.
module sccb_tick_gen #(
    parameter int QUARTER = 62
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [CW-1:0] LAST = CW'(QUARTER - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST) && !clear;

endmodule

// File: rtl/sccb_master.sv
// Byte-level SCCB write master: START, ID/sub-address/data bytes with released
// 9th bit, STOP, all on quarter-tick boundaries of the SIOC period.
module sccb_master
    import sccb_pkg::*;
#(
    parameter int         CLK_FREQ    = 25000000,
    parameter int         SCCB_FREQ   = 100000,
    parameter logic [7:0] CAMERA_ADDR = OV7670_WRITE_ID
) (
    input  logic   clk,
    input  logic   rst,
    sccb_if.master bus
);

    localparam int QUARTER = CLK_FREQ / (4 * SCCB_FREQ);

    localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(SCCB_BITS_PER_BYTE - 1);
    localparam logic [BIT_W-1:0]  BIT_LSB   = BIT_W'(1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(SCCB_BYTES - 1);

    generate
        if (QUARTER < 2) begin : g_quarter_check
            $error("sccb_master: CLK_FREQ/(4*SCCB_FREQ) must be at least 2");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [1:0]        r_quarter;
    logic [BIT_W-1:0]  r_bit;
    logic [BYTE_W-1:0] r_byte;
    logic [23:0]       r_shift;
    logic              r_ready;
    logic              r_sioc_oe;
    logic              r_siod_oe;
    logic              w_tick;
    logic              w_clear;

    // Holding the divider in clear while idle restarts it on the accept edge.
    assign w_clear = (r_state == IDLE);

    sccb_tick_gen #(.QUARTER(QUARTER)) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_quarter <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_shift   <= '0;
            r_ready   <= 1'b1;
            r_sioc_oe <= 1'b0;
            r_siod_oe <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift   <= {CAMERA_ADDR, bus.address, bus.data};
                        r_ready   <= 1'b0;
                        r_state   <= START;
                        r_quarter <= '0;
                        r_bit     <= BIT_FIRST;
                        r_byte    <= '0;
                        r_siod_oe <= 1'b1;
                        r_sioc_oe <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_quarter == 2'd0) begin
                            r_quarter <= 2'd1;
                            r_sioc_oe <= 1'b1;
                        end else begin
                            r_state   <= BIT;
                            r_quarter <= 2'd0;
                            r_siod_oe <= ~r_shift[23];
                        end
                    end
                end
                BIT: begin
                    if (w_tick) begin
                        r_quarter <= r_quarter + 2'd1;
                        case (r_quarter)
                            2'd1: r_sioc_oe <= 1'b0;
                            2'd3: begin
                                r_sioc_oe <= 1'b1;
                                // Shifting only on data bits leaves the next byte's MSB on top at the ACK slot.
                                if (r_bit != '0) begin
                                    r_shift   <= {r_shift[22:0], 1'b0};
                                    r_bit     <= r_bit - 1'b1;
                                    r_siod_oe <= (r_bit == BIT_LSB) ? 1'b0 : ~r_shift[22];
                                end else if (r_byte == BYTE_LAST) begin
                                    r_state   <= STOP;
                                    r_siod_oe <= 1'b1;
                                end else begin
                                    r_byte    <= r_byte + 1'b1;
                                    r_bit     <= BIT_FIRST;
                                    r_siod_oe <= ~r_shift[23];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_quarter <= r_quarter + 2'd1;
                        case (r_quarter)
                            2'd0: r_sioc_oe <= 1'b0;
                            2'd1: r_siod_oe <= 1'b0;
                            2'd3: begin
                                r_state <= IDLE;
                                r_ready <= 1'b1;
                                r_bit   <= '0;
                                r_byte  <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.SIOC_oe = r_sioc_oe;
    assign bus.SIOD_oe = r_siod_oe;

endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: open-drain line decoder with a frame scoreboard, table of
// single writes, plus busy-ignore, back-to-back and reset-abort sequences.
module tb_sccb_master;

    localparam int         CLK_FREQ     = 1600;
    localparam int         SCCB_FREQ    = 100;
    localparam int         Q            = 4;
    localparam int         FRAME_CYCLES = 114 * Q + 1;
    localparam logic [7:0] CAM_ID       = 8'h42;
    localparam int         TIMEOUT      = 1000;

    typedef struct {
        logic [7:0] address;
        logic [7:0] data;
        bit         busyPoke;
        int         latency;
    } vector_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sccb_if bus();

    sccb_master #(
        .CLK_FREQ    (CLK_FREQ),
        .SCCB_FREQ   (SCCB_FREQ),
        .CAMERA_ADDR (CAM_ID)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [23:0] scoreboard[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Open-drain line decoder: a line reads low whenever its oe is 1.
    logic        pSioc = 1'b1;
    logic        pSiod = 1'b1;
    int          runLen = 0;
    int          riseCount = 0;
    bit          inFrame = 1'b0;
    logic [23:0] gotBytes = '0;
    logic [2:0]  ackBits = '0;
    int          startCount = 0;
    int          stopCount = 0;
    int          cycleCount = 0;
    int          lastStopCycle = -1000;
    int          lastGap = 0;

    always @(negedge clk) begin : decoder
        logic        sioc;
        logic        siod;
        int          expLow;
        logic [23:0] expBytes;
        sioc = !bus.SIOC_oe;
        siod = !bus.SIOD_oe;
        cycleCount++;
        if (rst) begin
            inFrame   = 1'b0;
            riseCount = 0;
        end else begin
            if (pSioc && sioc && pSiod && !siod) begin
                checkOutput("start_when_idle", 32'(inFrame), 32'd0);
                inFrame    = 1'b1;
                riseCount  = 0;
                gotBytes   = '0;
                ackBits    = '0;
                startCount++;
                lastGap    = cycleCount - lastStopCycle;
            end else if (pSioc && sioc && !pSiod && siod) begin
                checkOutput("stop_inside_frame", 32'(inFrame), 32'd1);
                if (inFrame) begin
                    checkOutput("stop_after_bits", riseCount, 28);
                    stopCount++;
                    lastStopCycle = cycleCount;
                    if (scoreboard.size() == 0) begin
                        checkOutput("unexpected_frame_queue_depth", 32'(scoreboard.size()), 32'd1);
                    end else begin
                        expBytes = scoreboard.pop_front();
                        checkOutput("frame_bytes", 32'(gotBytes), 32'(expBytes));
                        checkOutput("ack_slots_released", 32'(ackBits), 32'h7);
                    end
                end
                inFrame = 1'b0;
            end
            if (inFrame && !pSioc && sioc) begin
                riseCount++;
                expLow = (riseCount == 1) ? 3 * Q : ((riseCount == 28) ? Q : 2 * Q);
                checkOutput("sioc_low_cycles", runLen, expLow);
                if (riseCount <= 27) begin
                    if ((riseCount - 1) % 9 < 8) gotBytes = {gotBytes[22:0], siod};
                    else ackBits = {ackBits[1:0], siod};
                end
            end
            if (inFrame && pSioc && !sioc && riseCount > 0) begin
                checkOutput("sioc_high_cycles", runLen, 2 * Q);
            end
        end
        runLen = (sioc === pSioc) ? runLen + 1 : 1;
        pSioc  = sioc;
        pSiod  = siod;
    end

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] dat, input bit expectFrame);
        bus.address = addr;
        bus.data    = dat;
        bus.start   = 1'b1;
        if (expectFrame) scoreboard.push_back({CAM_ID, addr, dat});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    vector_t vectors[4];
    int      n;
    int      expFrames;
    int      expStarts;
    int      highCycles;

    initial begin
        vectors[0] = '{8'h12, 8'h80, 1'b1, FRAME_CYCLES};
        vectors[1] = '{8'hFF, 8'h00, 1'b0, FRAME_CYCLES};
        vectors[2] = '{8'h00, 8'hFF, 1'b0, FRAME_CYCLES};
        vectors[3] = '{8'hA5, 8'h5A, 1'b0, FRAME_CYCLES};
        expFrames   = 0;
        expStarts   = 0;
        bus.start   = 1'b0;
        bus.address = 8'h00;
        bus.data    = 8'h00;

        // Reset held for three edges with a start pulse that must be ignored.
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        checkOutput("reset_ready", 32'(bus.ready), 32'd1);
        checkOutput("reset_sioc_oe", 32'(bus.SIOC_oe), 32'd0);
        checkOutput("reset_siod_oe", 32'(bus.SIOD_oe), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("idle_after_reset_ready", 32'(bus.ready), 32'd1);
        checkOutput("no_frame_from_reset_start", startCount, 0);

        $display("[TB] single writes");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vectors[i].address, vectors[i].data, 1'b1);
            expFrames++;
            expStarts++;
            checkOutput("ready_low_after_start", 32'(bus.ready), 32'd0);
            checkOutput("siod_first_fall", 32'(bus.SIOD_oe), 32'd1);
            n = 1;
            while (bus.ready !== 1'b1 && n < TIMEOUT) begin
                @(negedge clk);
                n++;
                if (vectors[i].busyPoke && n == 100) begin
                    bus.address = 8'h55;
                    bus.start   = 1'b1;
                end
                if (vectors[i].busyPoke && n == 101) bus.start = 1'b0;
            end
            checkOutput("ready_latency", n, vectors[i].latency);
            repeat (12) @(negedge clk);
            checkOutput("stop_count", stopCount, expFrames);
            checkOutput("start_count", startCount, expStarts);
            checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
        end

        $display("[TB] back-to-back writes");
        bus.address = 8'h11;
        bus.data    = 8'h01;
        bus.start   = 1'b1;
        scoreboard.push_back({CAM_ID, 8'h11, 8'h01});
        @(negedge clk);
        checkOutput("btb_first_ready_low", 32'(bus.ready), 32'd0);
        n = 1;
        while (bus.ready !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("btb_first_latency", n, FRAME_CYCLES);
        highCycles  = 1;
        bus.address = 8'h40;
        bus.data    = 8'hD0;
        scoreboard.push_back({CAM_ID, 8'h40, 8'hD0});
        @(negedge clk);
        if (bus.ready === 1'b1) highCycles++;
        checkOutput("btb_ready_high_cycles", highCycles, 1);
        bus.start = 1'b0;
        n = 1;
        while (bus.ready !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("btb_second_latency", n, FRAME_CYCLES);
        checkOutput("btb_stop_to_start_gap", lastGap, 2 * Q + 1);
        expFrames += 2;
        expStarts += 2;
        repeat (12) @(negedge clk);
        checkOutput("btb_stop_count", stopCount, expFrames);
        checkOutput("btb_start_count", startCount, expStarts);

        $display("[TB] reset abort");
        applyStimulus(8'h3A, 8'h5C, 1'b0);
        expStarts++;
        n = 1;
        while (n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_busy_before_reset", 32'(bus.ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_ready", 32'(bus.ready), 32'd1);
        checkOutput("abort_sioc_oe", 32'(bus.SIOC_oe), 32'd0);
        checkOutput("abort_siod_oe", 32'(bus.SIOD_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(8'h0C, 8'h04, 1'b1);
        expFrames++;
        expStarts++;
        n = 1;
        while (bus.ready !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("post_abort_latency", n, FRAME_CYCLES);
        repeat (12) @(negedge clk);
        checkOutput("post_abort_stop_count", stopCount, expFrames);
        checkOutput("post_abort_start_count", startCount, expStarts);
        checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sccb_master.md
# sccb_master

Byte-level SCCB (I2C-like) write master for the OV7670 camera. It accepts one register-address/data pair per `start` pulse from the register-configuration sequencer and serialises a 3-phase write on the open-drain SIOC/SIOD lines: device ID, sub-address, then data. It holds `ready` low for the whole transaction. It sits between the configuration FSM and the board's tri-state pads.

## Interface
- `CLK_FREQ`, default 25000000: system clock in Hz.
- `SCCB_FREQ`, default 100000: SIOC frequency in Hz. `QUARTER = CLK_FREQ/(4*SCCB_FREQ)`, integer floor; it must be at least 2, which is checked by an elaboration assertion.
- `CAMERA_ADDR`, default 8'h42: 8-bit write ID byte sent in phase 1.
- `clk` in 1: the only clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a write. It is sampled only while `ready`=1.
- `address` in 8: camera register sub-address.
- `data` in 8: register value.
- `ready` out 1: 1 means idle and able to accept `start`.
- `SIOC_oe` out 1: 1 pulls SIOC low; 0 releases it (pulled up externally).
- `SIOD_oe` out 1: 1 pulls SIOD low; 0 releases it.

## Operation
- Reset values: `ready`=1, `SIOC_oe`=0, `SIOD_oe`=0, state IDLE, all counters 0. Outputs are registered.
- **IDLE**
  - Both lines are released and `ready`=1.
  - When `start`=1, latch the shift bytes {CAMERA_ADDR, `address`, `data`}, clear `ready`, and go to START.
- **START** (2 quarters): quarter 0 drives `SIOD_oe`=1 with SIOC released; quarter 1 drives `SIOC_oe`=1.
- **BIT** (27 slots = 3 bytes × 9 bits, 4 quarters each):
  - q0: SIOC low; SIOD is updated to the current bit.
  - q1: SIOC low.
  - q2 and q3: SIOC released.
  - Bits 0..7 of each byte are sent MSB first: bit value 0 gives `SIOD_oe`=1, bit value 1 gives `SIOD_oe`=0.
  - The 9th bit is the SCCB don't-care/ACK slot: SIOD is released and not sampled. There is no SIOD input.
- **STOP** (4 quarters):
  - q0: SIOC low, SIOD low.
  - q1: SIOC released, SIOD low.
  - q2 and q3: SIOD released (bus-free time).
  - Then go to IDLE and set `ready`=1.
- Bit index counts 8..0 and byte index counts 0..2. Counter widths are $clog2 of the max value + 1; the counters do not wrap except back to reset values at IDLE.
- `start` while busy is ignored. Input values are not re-sampled mid-transaction.
- Reset mid-transaction aborts within one cycle: lines are released and `ready`=1. The partial frame is abandoned; the camera resynchronises on the next START.

## Timing
- All line edges are aligned to quarter-tick boundaries, one tick every QUARTER cycles. The tick counter restarts on acceptance of `start`.
- `ready` falls on the cycle after `start` is sampled. The upstream FSM relies on seeing `ready`=0 exactly one cycle after asserting `start`.
- First `SIOD_oe` rise: 1 cycle after `start` is sampled.
- Transaction length: 2 + 108 + 4 = 114 quarters. `ready` returns high 114·QUARTER + 1 cycles after the `start` sample edge. That is 7069 cycles at the defaults (QUARTER=62).
- `start` asserted on the same cycle `ready` returns high is accepted. Back-to-back transactions then have no gap beyond STOP quarters q2 and q3.
- SIOD never changes while SIOC is released, except for the START falling edge and the STOP rising edge.

## Structure
- Shared package `sccb_pkg` holds:
  - state localparams IDLE/START/BIT/STOP;
  - `SCCB_BITS_PER_BYTE`=9 and `SCCB_BYTES`=3;
  - the default OV7670 write ID 8'h42.
- One sub-module, `sccb_tick_gen`:
  - parameter QUARTER;
  - inputs `clk`, `rst`, `clear`;
  - outputs a one-cycle `tick` every QUARTER cycles.
- The FSM and shifter stay in `sccb_master`.

## Test plan
Parameters: CLK_FREQ=1600, SCCB_FREQ=100, so QUARTER=4. The bench open-drain model resolves the line as low if its `oe`=1.
- **Reset:** hold `rst` 3 cycles. Expect `ready`=1 and `SIOC_oe`=`SIOD_oe`=0. Pulse `start` during `rst`: no transaction.
- **Single write:** `address`=8'h12, `data`=8'h80, one-cycle `start`.
  - `ready`=0 on the next cycle.
  - The bench decoder sees START, bytes 42, 12, 80 MSB first with the 9th bit released each time, then STOP.
  - `ready`=1 exactly 457 cycles after the start edge.
- **Busy ignore:** pulse `start` with `address`=8'h55 mid-transaction. The decoded bytes are unchanged and only one STOP occurs.
- **Back-to-back:** hold `start`=1 continuously with 8'h11/8'h01, then 8'h40/8'hD0. Expect two frames separated by exactly the STOP bus-free quarters and `ready` high for 1 cycle between them.
- **Reset abort:** assert `rst` at cycle 200 of a transaction. Next cycle: `ready`=1 and both `oe`=0. A following write decodes correctly.
- **Protocol checker:** SIOD is stable whenever SIOC is high, except at START/STOP. SIOC high and low phases are each 8 cycles.
